// File: rtl/dpram_burst_reader_pkg.sv
// Shared definitions for the dual-port RAM burst reader and its buffer.
package dpram_burst_reader_pkg;

  // Burst reader control states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } rd_state_e;

  // Smallest buffer that sustains one word per clock across the two-cycle read path.
  localparam int unsigned BufDepthDefault = 4;

endpackage

// File: rtl/dpram_burst_reader_rd_fifo.sv
// Synchronous FIFO holding returned RAM words plus their end-of-burst flag.
// Read side is combinational from the head entry; count is exported for credit checks.
module dpram_burst_reader_rd_fifo #(
  parameter int unsigned dWidth = 8,
  parameter int unsigned Depth  = 4,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [dWidth-1:0] i_data,
  input  logic              i_last,
  input  logic              i_pop,
  output logic [dWidth-1:0] o_data,
  output logic              o_last,
  output logic              o_empty,
  output logic [CntW-1:0]   o_count
);

  localparam logic [CntW-1:0] CntDepth = CntW'(Depth);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

  logic [dWidth:0]   r_mem [Depth];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;

  // Status, head entry and accepted push/pop strobes.
  always_comb begin
    o_empty   = (r_count == '0);
    w_full    = (r_count == CntDepth);
    w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    w_do_push = i_push && (!w_full || w_do_pop);
    o_data    = r_mem[r_rd_ptr][dWidth-1:0];
    o_last    = r_mem[r_rd_ptr][dWidth];
    o_count   = r_count;
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= {i_last, i_data};
    end
  end

  // Pointers and occupancy; flush empties the FIFO and wins over push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dpram_burst_reader.sv
// Burst read client for one port of a dual-port RAM. Issues sequential reads from a
// base address and returns the words as a valid/ready stream. A credit check on
// buffer occupancy plus in-flight reads keeps the buffer from overflowing.
module dpram_burst_reader
  import dpram_burst_reader_pkg::*;
#(
  parameter int unsigned dWidth    = 8,
  parameter int unsigned aWidth    = 10,
  parameter int unsigned BUF_DEPTH = BufDepthDefault
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [aWidth-1:0] i_base_addr,
  input  logic [aWidth:0]   i_length,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [aWidth-1:0] o_mem_addr,
  output logic              o_mem_we,
  input  logic [dWidth-1:0] i_mem_q,
  output logic [dWidth-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam logic [SumW-1:0]   DepthLim = SumW'(BUF_DEPTH);
  localparam logic [aWidth:0]   LenOne   = (aWidth + 1)'(1);
  localparam logic [aWidth-1:0] AddrOne  = aWidth'(1);

  rd_state_e         r_state;
  logic              r_busy;
  logic              r_done;
  logic [aWidth-1:0] r_mem_addr;
  logic [aWidth:0]   r_remaining;   // reads still to issue after the current one
  logic              r_p1_vld;      // address presented, RAM samples it next edge
  logic              r_p1_last;
  logic              r_p2_vld;      // i_mem_q carries that read's data this cycle
  logic              r_p2_last;
  logic [dWidth-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;

  logic [CntW-1:0]   w_fifo_count;
  logic              w_fifo_empty;
  logic [dWidth-1:0] w_fifo_data;
  logic              w_fifo_last;
  logic [SumW-1:0]   w_credit_sum;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_out_load;
  logic              w_pop;
  logic              w_final_xfer;

  // Credit check, read issue, output-stage load and end-of-burst detection.
  always_comb begin
    w_credit_sum = SumW'(w_fifo_count) + SumW'(r_p1_vld) + SumW'(r_p2_vld);
    w_credit_ok  = (w_credit_sum < DepthLim);
    w_issue      = (r_state == StIssue) && w_credit_ok && !i_abort;
    w_out_load   = !r_out_valid || i_out_ready;
    w_pop        = w_out_load && !w_fifo_empty;
    w_final_xfer = r_out_valid && i_out_ready && r_out_last;
  end

  // Control FSM with address/remaining counters and the two-stage in-flight pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_addr  <= '0;
      r_remaining <= '0;
      r_p1_vld    <= 1'b0;
      r_p1_last   <= 1'b0;
      r_p2_vld    <= 1'b0;
      r_p2_last   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_p2_vld  <= r_p1_vld;
      r_p2_last <= r_p1_last;
      r_p1_vld  <= 1'b0;
      r_p1_last <= 1'b0;
      if (i_abort) begin
        // Drop everything in flight; late RAM data is never tagged valid.
        r_state   <= StIdle;
        r_busy    <= 1'b0;
        r_p2_vld  <= 1'b0;
        r_p2_last <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start) begin
              if (i_length == '0) begin
                r_done <= 1'b1;
              end else begin
                // The first read is issued here; the buffer is empty so no credit check.
                r_mem_addr  <= i_base_addr;
                r_remaining <= i_length - LenOne;
                r_p1_vld    <= 1'b1;
                r_busy      <= 1'b1;
                if (i_length == LenOne) begin
                  r_p1_last <= 1'b1;
                  r_state   <= StDrain;
                end else begin
                  r_state   <= StIssue;
                end
              end
            end
          end
          StIssue: begin
            if (w_issue) begin
              r_mem_addr  <= r_mem_addr + AddrOne;
              r_remaining <= r_remaining - LenOne;
              r_p1_vld    <= 1'b1;
              if (r_remaining == LenOne) begin
                r_p1_last <= 1'b1;
                r_state   <= StDrain;
              end
            end
          end
          StDrain: begin
            // The tagged last word leaving the output stage means the burst is empty.
            if (w_final_xfer) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Registered stream output stage, refilled from the FIFO head whenever it can advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (i_abort) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid <= !w_fifo_empty;
      if (!w_fifo_empty) begin
        r_out_data <= w_fifo_data;
        r_out_last <= w_fifo_last;
      end else begin
        r_out_last <= 1'b0;
      end
    end
  end

  dpram_burst_reader_rd_fifo #(
    .dWidth (dWidth),
    .Depth  (BUF_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_abort),
    .i_push  (r_p2_vld),
    .i_data  (i_mem_q),
    .i_last  (r_p2_last),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_last  (w_fifo_last),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_we    = 1'b0;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Bench for dpram_burst_reader: RAM model preloaded with ram[i] = i[7:0] ^ 8'h5A,
// expected words queued by the stimulus and checked by an independent monitor.
module tb_dpram_burst_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_q;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_pop    = 0;
  int max_count = 0;
  logic [8:0] exp_q [$];   // {last, data}
  logic [7:0] ram [1024];

  dpram_burst_reader #(
    .dWidth    (8),
    .aWidth    (10),
    .BUF_DEPTH (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_length    (length),
    .i_abort     (abort),
    .o_busy      (busy),
    .o_done      (done),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .i_mem_q     (mem_q),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = i[7:0] ^ 8'h5A;
  end

  // One-cycle registered read port.
  always @(posedge clk) mem_q <= ram[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stream rules.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e;
    int         cnt;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (done) n_done++;
        check("last_needs_valid", 32'(out_last & ~out_valid), 32'd0);
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(prev_data));
          check("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
          end else begin
            e = exp_q.pop_front();
            check("word", 32'({out_last, out_data}), 32'(e));
          end
          n_pop++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        cnt = int'(dut.u_fifo.r_count);
        if (cnt > max_count) max_count = cnt;
      end
    end
  end

  // Drives a one-cycle start; returns 1 time unit after the sampling edge.
  task automatic pulse_start(input logic [9:0] b, input logic [10:0] len);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    length    = len;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_model(input logic [9:0] b, input int len);
    logic [9:0] a;
    for (int i = 0; i < len; i++) begin
      a = b + 10'(i);
      exp_q.push_back({(i == len - 1), ram[a]});
    end
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int p0;
    logic seen;
    logic [9:0] t2_addr [4];
    t2_addr[0] = 10'h3FE;
    t2_addr[1] = 10'h3FF;
    t2_addr[2] = 10'h000;
    t2_addr[3] = 10'h001;

    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: four words from 0x010, latency and done timing.
    exp_q.push_back(9'h04A); exp_q.push_back(9'h04B);
    exp_q.push_back(9'h048); exp_q.push_back(9'h149);
    d0 = n_done;
    pulse_start(10'h010, 11'd4);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk); check("t1_valid_e0", 32'(out_valid), 32'd0);
    @(negedge clk); check("t1_valid_e1", 32'(out_valid), 32'd0);
    @(negedge clk); check("t1_valid_e2", 32'(out_valid), 32'd0);
    @(negedge clk); check("t1_valid_e3", 32'(out_valid), 32'd1);
    check("t1_first_data", 32'(out_data), 32'h4A);
    @(negedge clk); check("t1_valid_e4", 32'(out_valid), 32'd1);
    @(negedge clk); check("t1_valid_e5", 32'(out_valid), 32'd1);
    @(negedge clk); check("t1_valid_e6", 32'(out_valid), 32'd1);
    check("t1_last_e6", 32'(out_last), 32'd1);
    @(negedge clk); check("t1_done", 32'(done), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_valid_after", 32'(out_valid), 32'd0);
    @(negedge clk); check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_done_count", 32'(n_done - d0), 32'd1);
    check("t1_we", 32'(mem_we), 32'd0);

    // 2: address wrap at the top of memory.
    exp_q.push_back(9'h0A4); exp_q.push_back(9'h0A5);
    exp_q.push_back(9'h05A); exp_q.push_back(9'h15B);
    pulse_start(10'h3FE, 11'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_addr", 32'(mem_addr), 32'(t2_addr[i]));
    end
    wait_done("t2_done", 20);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: sixteen words under random backpressure.
    max_count = 0;
    d0 = n_done;
    push_model(10'h020, 16);
    pulse_start(10'h020, 11'd16);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    check("t3_done", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t3_done_count", 32'(n_done - d0), 32'd1);
    check("t3_max_count_le4", 32'(max_count <= 4), 32'd1);

    // 4: zero-length burst.
    d0 = n_done;
    pulse_start(10'h055, 11'd0);
    @(negedge clk);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4_done_pulse", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_valid_low", 32'(out_valid), 32'd0);
      check("t4_busy_low", 32'(busy), 32'd0);
    end
    check("t4_done_count", 32'(n_done - d0), 32'd1);

    // 5: abort after three of ten words, then a fresh two-word burst.
    d0 = n_done;
    p0 = n_pop;
    push_model(10'h040, 10);
    pulse_start(10'h040, 11'd10);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (n_pop - p0 >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_three_words", 32'(seen), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    check("t5_valid_low", 32'(out_valid), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    check("t5_no_done", 32'(n_done - d0), 32'd0);
    check("t5_popped", 32'(n_pop - p0), 32'd3);
    exp_q.push_back(9'h05A); exp_q.push_back(9'h15B);
    pulse_start(10'h100, 11'd2);
    wait_done("t5_restart_done", 20);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t5_restart_pops", 32'(n_pop - p0), 32'd5);

    // 6: asynchronous reset mid-burst, then start-while-busy is ignored.
    push_model(10'h200, 8);
    pulse_start(10'h200, 11'd8);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    d0 = n_done;
    p0 = n_pop;
    push_model(10'h300, 8);
    pulse_start(10'h300, 11'd8);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = 10'h000; length = 11'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t6_done", 40);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t6_pops", 32'(n_pop - p0), 32'd8);
    check("t6_done_count", 32'(n_done - d0), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_idle_after", 32'(busy), 32'd0);
    check("t6_no_extra_done", 32'(n_done - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
